risc_seq_controller: RTL

//  Multi-cycle control sequencer for the single-cycle RISC-V datapath. Decodes op_func, drives every datapath control.

---
 rtl/risc_ctrl_pkg.sv | 45 ++++
 rtl/risc_main_decoder.sv | 80 ++++++++
 rtl/risc_seq_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the RISC-V sequencer: opcodes, ALU/immediate select codes, FSM states.
package risc_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Returns {supported, ALUControl} for an ALU-class funct3; sltu/sltiu are not supported.
    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return {1'b1, ALU_ADD};
            3'b001:  return {1'b1, ALU_SLL};
            3'b010:  return {1'b1, ALU_SLT};
            3'b100:  return {1'b1, ALU_XOR};
            3'b101:  return {1'b1, ALU_SRL};
            3'b110:  return {1'b1, ALU_OR};
            3'b111:  return {1'b1, ALU_AND};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/risc_main_decoder.sv
// Combinational decode of {Instr[30], funct3, opcode} plus flags into datapath control intent.
module risc_main_decoder
    import risc_ctrl_pkg::*;
(
    input  logic [10:0] op_func,
    input  logic        ZF,
    input  logic        SF,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  imm_src,
    output logic        alu_src,
    output logic        result_src,
    output logic        branch_taken,
    output logic        is_mem,
    output logic        is_store,
    output logic        reg_wr,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic [3:0] f3_dec;

    assign opcode = op_func[6:0];
    assign funct3 = op_func[9:7];
    assign f7b5   = op_func[10];
    assign f3_dec = f3_alu(funct3);

    always_comb begin
        alu_ctrl     = ALU_ADD;
        imm_src      = IMM_I;
        alu_src      = 1'b0;
        result_src   = 1'b0;
        branch_taken = 1'b0;
        is_mem       = 1'b0;
        is_store     = 1'b0;
        reg_wr       = 1'b0;
        illegal      = 1'b0;
        case (opcode)
            OP_R: begin
                reg_wr   = 1'b1;
                alu_ctrl = (funct3 == 3'b000 && f7b5) ? ALU_SUB : f3_dec[2:0];
                illegal  = !f3_dec[3] || (f7b5 && funct3 != 3'b000);
            end
            OP_I: begin
                // Bit 30 is immediate data except on shifts, where it would select srai.
                reg_wr   = 1'b1;
                alu_src  = 1'b1;
                alu_ctrl = f3_dec[2:0];
                illegal  = !f3_dec[3] || (f7b5 && funct3[1:0] == 2'b01);
            end
            OP_B: begin
                alu_ctrl = ALU_SUB;
                imm_src  = IMM_B;
                case (funct3)
                    3'b000:  branch_taken = ZF;
                    3'b001:  branch_taken = !ZF;
                    3'b100:  branch_taken = SF;
                    3'b101:  branch_taken = !SF;
                    default: illegal      = 1'b1;
                endcase
            end
            OP_LOAD: begin
                alu_src    = 1'b1;
                is_mem     = 1'b1;
                result_src = 1'b1;
                illegal    = funct3 != 3'b010;
            end
            OP_STORE: begin
                alu_src  = 1'b1;
                imm_src  = IMM_S;
                is_mem   = 1'b1;
                is_store = 1'b1;
                illegal  = funct3 != 3'b010;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc_seq_controller.sv
// Multi-cycle run/step sequencer: FETCH/EXEC/MEM with memory-ready timeout, retire counter and sticky fault.
module risc_seq_controller
    import risc_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [10:0]      op_func,
    input  logic             ZF,
    input  logic             SF,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemWrite,
    output logic             ResultSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       dbg_state
);

    localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             step_flag_q, step_flag_d;
    logic             fault_q, fault_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    logic [2:0] dec_alu;
    logic [1:0] dec_imm;
    logic       dec_alu_src, dec_result_src, dec_taken;
    logic       dec_is_mem, dec_is_store, dec_reg_wr, dec_illegal;

    risc_main_decoder u_dec (
        .op_func      (op_func),
        .ZF           (ZF),
        .SF           (SF),
        .alu_ctrl     (dec_alu),
        .imm_src      (dec_imm),
        .alu_src      (dec_alu_src),
        .result_src   (dec_result_src),
        .branch_taken (dec_taken),
        .is_mem       (dec_is_mem),
        .is_store     (dec_is_store),
        .reg_wr       (dec_reg_wr),
        .illegal      (dec_illegal)
    );

    always_comb begin
        state_d     = state_q;
        step_flag_d = step_flag_q;
        fault_d     = fault_q;
        tcnt_d      = tcnt_q;
        count_d     = count_q;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 1'b0;
        RegWrite    = 1'b0;
        ALUSrc      = 1'b0;
        MemWrite    = 1'b0;
        ResultSrc   = 1'b0;
        ALUControl  = ALU_ADD;
        ImmSrc      = IMM_I;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d     = ST_FETCH;
                    step_flag_d = 1'b0;
                end else if (step) begin
                    state_d     = ST_FETCH;
                    step_flag_d = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec_illegal) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    ALUControl = dec_alu;
                    ImmSrc     = dec_imm;
                    ALUSrc     = dec_alu_src;
                    if (dec_is_mem) begin
                        state_d = ST_MEM;
                        tcnt_d  = '0;
                    end else begin
                        RegWrite = dec_reg_wr;
                        PCWrite  = 1'b1;
                        PCSrc    = dec_taken;
                        retire   = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                // Address path stays driven for the whole wait; write enables only on the ready cycle.
                ALUControl = dec_alu;
                ImmSrc     = dec_imm;
                ALUSrc     = dec_alu_src;
                if (mem_ready) begin
                    MemWrite  = dec_is_store;
                    RegWrite  = dec_result_src;
                    ResultSrc = dec_result_src;
                    PCWrite   = 1'b1;
                    retire    = 1'b1;
                end else if (tcnt_q == TMAX) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = ST_FAULT;
        endcase
        if (retire) begin
            count_d     = count_q + 1'b1;
            step_flag_d = 1'b0;
            state_d     = (run && !step_flag_q) ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_flag_q <= 1'b0;
            fault_q     <= 1'b0;
            tcnt_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_flag_q <= step_flag_d;
            fault_q     <= fault_d;
            tcnt_q      <= tcnt_d;
            count_q     <= count_d;
        end
    end

    assign halted      = (state_q == ST_IDLE) || (state_q == ST_FAULT);
    assign fault       = fault_q;
    assign instr_count = count_q;
    assign dbg_state   = state_q;

endmodule
